// File: rtl/mem_access_unit.sv
// mem_access_unit: splits RV32I loads/stores into MEM_BYTES-wide memory beats,
// reassembles and extends load data, and pulses done_o when the access ends.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (reject misaligned accesses with err_o).
module mem_access_unit #(
   parameter int unsigned MEM_BYTES   = 1,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_i,
   input  logic                   we_i,
   input  logic [2:0]             func3_i,
   input  logic [31:0]            addr_i,
   input  logic [31:0]            wdata_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [31:0]            rdata_o,
   output logic                   err_o,
   output logic                   mem_req_o,
   output logic                   mem_we_o,
   output logic [31:0]            mem_addr_o,
   output logic [MEM_BYTES-1:0]   mem_be_o,
   output logic [8*MEM_BYTES-1:0] mem_wdata_o,
   input  logic [8*MEM_BYTES-1:0] mem_rdata_i
);

   localparam int unsigned BeatW = 8 * MEM_BYTES;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e                 state_q, state_d;
   logic                   we_q;
   logic [2:0]             func3_q;
   logic [31:0]            addr_q;
   logic [31:0]            wdata_q;
   logic [1:0]             beat_q;
   logic [1:0]             cap_q;
   logic [MEM_LATENCY-1:0] pend_q;
   logic [31:0]            asm_q, asm_d;
   logic [31:0]            rdata_q;
   logic [31:0]            ext_data;
   logic                   trap_q, trap_hit;
   logic [2:0]             acc_size;
   logic [1:0]             last_beat;
   logic                   accept, issue, cap_fire, load_done;

   // Access size in bytes; anything not a defined load/store code is a word.
   function automatic logic [2:0] size_of(input logic we, input logic [2:0] f3);
      logic [2:0] s;
      case ({we, f3})
         4'b0000, 4'b0100, 4'b1000: s = 3'd1;
         4'b0001, 4'b0101, 4'b1001: s = 3'd2;
         default:                   s = 3'd4;
      endcase
      return s;
   endfunction

`ifdef MEM_MISALIGN_TRAP_EN
   logic [2:0] req_size;
   assign req_size = size_of(we_i, func3_i);
   assign trap_hit = (addr_i[2:0] & (req_size - 3'd1)) != 3'd0;
`else
   assign trap_hit = 1'b0;
`endif

   assign acc_size  = size_of(we_q, func3_q);
   assign last_beat = 2'((acc_size - 3'd1) / 3'(MEM_BYTES));
   assign accept    = (state_q == StIdle) && req_i;
   assign issue     = state_q == StIssue;
   assign cap_fire  = pend_q[MEM_LATENCY-1];
   assign load_done = (state_q == StDone) && !we_q && !trap_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (req_i) state_d = trap_hit ? StDone : StIssue;
         end
         StIssue: begin
            if (beat_q == last_beat) state_d = we_q ? StDone : StDrain;
         end
         StDrain: begin
            if (cap_fire && (cap_q == last_beat)) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   // Request latch, beat/capture counters, read-return delay line, assembly and result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         func3_q <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         beat_q  <= 2'd0;
         cap_q   <= 2'd0;
         pend_q  <= '0;
         asm_q   <= 32'd0;
         rdata_q <= 32'd0;
         trap_q  <= 1'b0;
      end else begin
         // Only load beats return data, so only they enter the delay line.
         pend_q[0] <= issue && !we_q;
         for (int i = 1; i < int'(MEM_LATENCY); i++) pend_q[i] <= pend_q[i-1];
         if (accept) begin
            we_q    <= we_i;
            func3_q <= func3_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            beat_q  <= 2'd0;
            cap_q   <= 2'd0;
            asm_q   <= 32'd0;
            trap_q  <= trap_hit;
         end
         if (issue) beat_q <= beat_q + 2'd1;
         if (cap_fire) begin
            cap_q <= cap_q + 2'd1;
            asm_q <= asm_d;
         end
         if (load_done) rdata_q <= ext_data;
      end
   end

   // Place the enabled bytes of the returning beat into the assembly register.
   always_comb begin
      asm_d = asm_q;
      for (int j = 0; j < int'(MEM_BYTES); j++) begin
         if ((32'(cap_q) * MEM_BYTES + 32'(j)) < 32'(acc_size)) begin
            asm_d[8*(32'(cap_q) * MEM_BYTES + 32'(j)) +: 8] = mem_rdata_i[8*j +: 8];
         end
      end
   end

   // Load result extension.
   always_comb begin
      case (func3_q)
         3'b000:  ext_data = {{24{asm_q[7]}}, asm_q[7:0]};
         3'b001:  ext_data = {{16{asm_q[15]}}, asm_q[15:0]};
         3'b100:  ext_data = {24'd0, asm_q[7:0]};
         3'b101:  ext_data = {16'd0, asm_q[15:0]};
         default: ext_data = asm_q;
      endcase
   end

   // Outputs: beat fields are zero outside ISSUE so idle/reset values are clean.
   always_comb begin
      busy_o      = (state_q != StIdle) || (req_i && rst);
      done_o      = state_q == StDone;
      mem_req_o   = issue;
      mem_we_o    = issue && we_q;
      mem_addr_o  = 32'd0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (issue) begin
         mem_addr_o  = addr_q + 32'(beat_q) * MEM_BYTES;
         mem_wdata_o = BeatW'(wdata_q >> (32'(beat_q) * BeatW));
         for (int j = 0; j < int'(MEM_BYTES); j++) begin
            mem_be_o[j] = (32'(beat_q) * MEM_BYTES + 32'(j)) < 32'(acc_size);
         end
      end
      rdata_o = load_done ? ext_data : rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
      err_o = done_o && trap_q;
`else
      err_o = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, reset abort sequence and
// random accesses checked against a byte-array memory reference model.
module tb_mem_access_unit;

   localparam int unsigned MB  = 2;
   localparam int unsigned LAT = 2;
   localparam int unsigned BW  = 8 * MB;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_i = 1'b0;
   logic          we_i = 1'b0;
   logic [2:0]    func3_i = 3'd0;
   logic [31:0]   addr_i = 32'd0;
   logic [31:0]   wdata_i = 32'd0;
   logic          busy_o, done_o, err_o, mem_req_o, mem_we_o;
   logic [31:0]   rdata_o, mem_addr_o;
   logic [MB-1:0] mem_be_o;
   logic [BW-1:0] mem_wdata_o, mem_rdata_i;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_BYTES(MB), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .func3_i(func3_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
      .rdata_o(rdata_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i)
   );

   typedef struct {
      logic          we;
      logic [31:0]   addr;
      logic [MB-1:0] be;
      logic [BW-1:0] wdata;
   } beat_t;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_lat;
      logic        exp_err;
   } vec_t;

   logic [7:0]    mem [1024] = '{default: 8'h00};
   logic [7:0]    ref_mem [1024] = '{default: 8'h00};
   logic [BW-1:0] rd_pipe [LAT] = '{default: '0};
   logic          b_req = 1'b0, b_we = 1'b0;
   logic [31:0]   b_addr = 32'd0;
   logic [MB-1:0] b_be = '0;
   logic [BW-1:0] b_wdata = '0;
   beat_t         beat_q[$];
   int            checks = 0;
   int            errors = 0;

   function automatic logic [BW-1:0] read_beat(input logic [31:0] a);
      logic [BW-1:0] r;
      for (int j = 0; j < int'(MB); j++) r[8*j +: 8] = mem[10'(a + 32'(j))];
      return r;
   endfunction

   // Sample the memory port mid-cycle; the memory acts on it at the next rising edge.
   always @(negedge clk) begin
      b_req   <= mem_req_o;
      b_we    <= mem_we_o;
      b_addr  <= mem_addr_o;
      b_be    <= mem_be_o;
      b_wdata <= mem_wdata_o;
      if (mem_req_o) beat_q.push_back('{mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o});
   end

   // Memory: byte-enabled writes; reads return through a LAT-deep pipe.
   always @(posedge clk) begin
      if (b_req && b_we) begin
         for (int j = 0; j < int'(MB); j++)
            if (b_be[j]) mem[10'(b_addr + 32'(j))] <= b_wdata[8*j +: 8];
      end
      if (b_req && !b_we) rd_pipe[0] <= read_beat(b_addr);
      for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata_i = rd_pipe[LAT-1];

   // Reference model helpers.
   function automatic int size_of(input logic we, input logic [2:0] f3);
      if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic bit is_trap(input logic we, input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
      return (a % 32'(size_of(we, f3))) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int          s;
      s = size_of(1'b0, f3);
      v = 32'd0;
      for (int i = 0; i < s; i++) v = v | (32'(ref_mem[10'(a + 32'(i))]) << (8 * i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   function automatic int exp_latency(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int nb;
      nb = (size_of(we, f3) + int'(MB) - 1) / int'(MB);
      if (is_trap(we, f3, a)) return 1;
      return we ? nb + 1 : nb + int'(LAT) + 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One access, called at a falling edge with the DUT idle. Checks protocol and beats
   // against the model and returns the observed result for the caller to judge.
   task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output int lat,
                         output logic err);
      int    s, nb, n;
      bit    trap, got, busy_ok;
      beat_t b;
      s    = size_of(we, f3);
      nb   = (s + int'(MB) - 1) / int'(MB);
      trap = is_trap(we, f3, addr);
      beat_q.delete();
      req_i = 1'b1; we_i = we; func3_i = f3; addr_i = addr; wdata_i = wdata;
      #1 check("busy_accept", 32'(busy_o), 32'd1);
      @(posedge clk);
      #1;
      req_i = 1'b0; we_i = ~we; func3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
      n = 0; got = 1'b0; busy_ok = 1'b1;
      while (!got && n < 64) begin
         @(negedge clk);
         n++;
         if (!busy_o) busy_ok = 1'b0;
         if (done_o) got = 1'b1;
      end
      check("done_seen", 32'(got), 32'd1);
      check("busy_hold", 32'(busy_ok), 32'd1);
      lat = n; rd = rdata_o; err = err_o;
      if (trap) nb = 0;
      check("beat_count", 32'(beat_q.size()), 32'(nb));
      for (int k = 0; k < nb && k < beat_q.size(); k++) begin
         b = beat_q[k];
         check("beat_addr", b.addr, addr + 32'(k * int'(MB)));
         check("beat_we", 32'(b.we), 32'(we));
         for (int j = 0; j < int'(MB); j++)
            check("beat_be", 32'(b.be[j]), 32'((k * int'(MB) + j) < s));
         if (we) check("beat_wdata", 32'(b.wdata), 32'(BW'(wdata >> (8 * k * int'(MB)))));
      end
      if (we && !trap)
         for (int i = 0; i < s; i++) ref_mem[10'(addr + 32'(i))] = 8'(wdata >> (8 * i));
      @(negedge clk);
      check("busy_after", 32'(busy_o), 32'd0);
      check("done_after", 32'(done_o), 32'd0);
      check("rdata_held", rdata_o, rd);
   endtask

   vec_t        vecs[$];
   logic [31:0] rd, last_rd, exp_rd;
   int          lat;
   logic        err;

   initial begin
      vecs.push_back('{1'b1, 3'd2, 32'h100, 32'h1234_5678, 32'h0000_0000, 3, 1'b0});
      vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0,         32'h1234_5678, 5, 1'b0});
      vecs.push_back('{1'b1, 3'd0, 32'h104, 32'hAAAA_AA80, 32'h1234_5678, 2, 1'b0});
      vecs.push_back('{1'b0, 3'd0, 32'h104, 32'h0,         32'hFFFF_FF80, 4, 1'b0});
      vecs.push_back('{1'b0, 3'd4, 32'h104, 32'h0,         32'h0000_0080, 4, 1'b0});
      vecs.push_back('{1'b1, 3'd1, 32'h106, 32'h5555_9234, 32'h0000_0080, 2, 1'b0});
      vecs.push_back('{1'b0, 3'd1, 32'h106, 32'h0,         32'hFFFF_9234, 4, 1'b0});
      vecs.push_back('{1'b0, 3'd5, 32'h106, 32'h0,         32'h0000_9234, 4, 1'b0});
      vecs.push_back('{1'b1, 3'd1, 32'h010, 32'h0000_BEEF, 32'h0000_9234, 2, 1'b0});
      vecs.push_back('{1'b0, 3'd5, 32'h010, 32'h0,         32'h0000_BEEF, 4, 1'b0});
`ifdef MEM_MISALIGN_TRAP_EN
      vecs.push_back('{1'b0, 3'd1, 32'h101, 32'h0,         32'h0000_BEEF, 1, 1'b1});
      vecs.push_back('{1'b0, 3'd3, 32'h100, 32'h0,         32'h1234_5678, 5, 1'b0});
      vecs.push_back('{1'b0, 3'd2, 32'h102, 32'h0,         32'h1234_5678, 1, 1'b1});
`else
      vecs.push_back('{1'b0, 3'd1, 32'h101, 32'h0,         32'h0000_3456, 4, 1'b0});
      vecs.push_back('{1'b0, 3'd3, 32'h100, 32'h0,         32'h1234_5678, 5, 1'b0});
      vecs.push_back('{1'b0, 3'd2, 32'h102, 32'h0,         32'h0080_1234, 5, 1'b0});
`endif

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_mem_req", 32'(mem_req_o), 32'd0);
      check("rst_mem_we", 32'(mem_we_o), 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'd0);
      check("rst_mem_be", 32'(mem_be_o), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata_o), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Directed vectors.
      foreach (vecs[i]) begin
         access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, lat, err);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      end

      // Abort an LW during its second beat.
      req_i = 1'b1; we_i = 1'b0; func3_i = 3'd2; addr_i = 32'h100;
      @(posedge clk);
      #1 req_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_in_issue", 32'(mem_req_o), 32'd1);
      rst = 1'b0;
      #1;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_done", 32'(done_o), 32'd0);
      check("abort_rdata", rdata_o, 32'd0);
      check("abort_mem_req", 32'(mem_req_o), 32'd0);
      check("abort_mem_addr", mem_addr_o, 32'd0);
      check("abort_mem_be", 32'(mem_be_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      access(1'b0, 3'd2, 32'h100, 32'h0, rd, lat, err);
      check("post_reset_rdata", rd, 32'h1234_5678);
      check("post_reset_latency", 32'(lat), 32'(exp_latency(1'b0, 3'd2, 32'h100)));
      last_rd = rd;

      // Random accesses against the reference model.
      for (int t = 0; t < 60; t++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] a, wd;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if (we && f3 > 3'd3) f3 = f3 - 3'd4;
         if (!we && f3 > 3'd5) f3 = 3'd3;
         a  = 32'($urandom_range(0, 1019));
         if ($urandom_range(0, 1) == 1) a = a & ~(32'(size_of(we, f3)) - 32'd1);
         wd = $urandom;
         exp_rd = (we || is_trap(we, f3, a)) ? last_rd : ref_load(f3, a);
         access(we, f3, a, wd, rd, lat, err);
         check("rand_rdata", rd, exp_rd);
         check("rand_latency", 32'(lat), 32'(exp_latency(we, f3, a)));
         check("rand_err", 32'(err), 32'(is_trap(we, f3, a)));
         last_rd = exp_rd;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit that sits between the MEM pipeline stage and the memory controller. It splits each RV32I load or store (byte, half, word) into beats of MEM_BYTES bytes, issues one beat per cycle, reassembles and sign- or zero-extends read data, and pulses `done_o` on completion. It holds `busy_o` high for the whole access so the pipeline control can stall upstream stages.

## Interface
Parameters:
- `MEM_BYTES`, 1: bytes per memory beat. Legal values are 1, 2 and 4.
- `MEM_LATENCY`, 1: cycles from address issue to read data valid on `mem_rdata_i`. Legal range is 1..4.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  access request. Sampled only in IDLE.
- `we_i`  in  1  1 = store, 0 = load.
- `func3_i`  in  3  RV32I funct3: LB/LH/LW/LBU/LHU or SB/SH/SW.
- `addr_i`  in  32  byte address of the access.
- `wdata_i`  in  32  store data. Bits above the access size are ignored.
- `busy_o`  out  1  high from the accept cycle until the cycle after `done_o`.
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  extended load result. Valid while `done_o` is high and held until the next accept.
- `err_o`  out  1  misaligned-access flag, qualified by `done_o`.
- `mem_req_o`  out  1  beat valid.
- `mem_we_o`  out  1  beat is a write.
- `mem_addr_o`  out  32  beat byte address.
- `mem_be_o`  out  MEM_BYTES  byte enables for the beat.
- `mem_wdata_o`  out  8*MEM_BYTES  write data for the beat, little-endian.
- `mem_rdata_i`  in  8*MEM_BYTES  read data for a beat, arriving MEM_LATENCY cycles after that beat is issued.

## Operation
- Access size is S = 1, 2 or 4 bytes, decoded from `func3_i[1:0]`. Beat count is B = ceil(S / MEM_BYTES).
- Beat k drives:
  - `mem_addr_o` = `addr_i` + k*MEM_BYTES;
  - `mem_be_o` set for bytes j where k*MEM_BYTES + j < S;
  - `mem_wdata_o` = bytes [k*MEM_BYTES +: MEM_BYTES] of `wdata_i`.
- The request fields (`we_i`, `func3_i`, `addr_i`, `wdata_i`) are latched at accept. Later changes on those inputs are ignored.
- State machine:
  - IDLE: if `req_i` is high, latch the request, clear the beat counters and go to ISSUE. If MEM_MISALIGN_TRAP_EN fires instead, go to DONE.
  - ISSUE: drive one beat per cycle. After beat B-1 is issued, a store goes to DONE and a load goes to DRAIN.
  - DRAIN: a read-capture counter collects `mem_rdata_i` bytes whose enable bits were set, placing them into a 32-bit assembly register. When all S bytes are captured, go to DONE.
  - DONE: assert `done_o` and drive `rdata_o` from the assembly register; return to IDLE.
- Captures overlap with issue. A delay line of depth MEM_LATENCY tracks which beats are outstanding.
- Load result extension:
  - LB: sign-extend bit 7.
  - LH: sign-extend bit 15.
  - LBU/LHU: zero-extend.
  - LW: no extension.
- Stores and errored accesses leave `rdata_o` unchanged.
- An undefined `func3_i` is treated as a word access.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `rdata_o`=0, `err_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_be_o`=0, `mem_wdata_o`=0. State is IDLE and all counters are 0.
- Accept happens at edge T0. Beat 0 is on the memory port during cycle T0+1.
- Store: `done_o` is high in cycle T0+B+1.
- Load: `done_o` is high in cycle T0+B+MEM_LATENCY+1.
- `busy_o` is combinationally high in the accept cycle and stays high through the DONE cycle.
- Back-to-back accesses: `req_i` is ignored in DONE. The next accept is possible on the first IDLE cycle, so the minimum gap is one cycle.
- `mem_req_o` is never high outside ISSUE.
- Asserting `rst` mid-access:
  - all outputs drop to their reset values immediately (asynchronous);
  - any partial store beats already written are not rolled back;
  - no `done_o` is produced for the aborted access.

## Configuration
- `MEM_MISALIGN_TRAP_EN`:
  - Defined: an access with `addr_i` mod S ≠ 0 issues no beats. `done_o` and `err_o` pulse together in cycle T0+1, and `rdata_o` is unchanged.
  - Undefined: `err_o` is tied to 0, and misaligned accesses are performed byte-exactly as described in Operation.

## Test plan
- MEM_BYTES=1, MEM_LATENCY=1: LW at 0x100 with memory bytes 78,56,34,12 → four read beats at 0x100–0x103, `rdata_o`=0x12345678, `done_o` at T0+6.
- MEM_BYTES=1: LB then LBU at a byte holding 0x80 → 0xFFFFFF80, then 0x00000080; LH of bytes 0x34,0x92 → 0xFFFF9234.
- MEM_BYTES=2: SW 0x12345678 at 0x200 → beats (0x200, be=11, 0x5678), then (0x202, be=11, 0x1234); `done_o` at T0+3.
- MEM_BYTES=4, MEM_LATENCY=3: SH 0xBEEF at 0x10 → one beat with be=0011 and wdata[15:0]=0xBEEF; LHU at 0x10 returns 0x0000BEEF at T0+5.
- MEM_MISALIGN_TRAP_EN defined: LW at 0x102 → no `mem_req_o`; `done_o`=`err_o`=1 at T0+1. With the macro undefined, the same access completes normally with `err_o`=0.
- Assert `rst` during beat 2 of an LW → all outputs are 0 within the same cycle; the next access after reset release completes correctly.
